branch_stack: RTL and testbench
===============================

// Module: branch_stack
// PURPOSE
// - Checkpoint store for in-flight branches: captures BS_ENTRY_PACKETs written by dispatch, one slot per B_MASK bit.
// - Accepts branch resolutions from execute.
// - Correct prediction: frees the slot and broadcasts the bit to clear.
// - Misprediction: drives restore state (map table, free list, ROB tail, b_mask, PC) back to dispatch/fetch and squashes younger slots.
// - Sits between Dispatch (producer of checkpoints, consumer of restore) and the branch FU.
// PARAMETERS
// - DEPTH     `B_MASK_WIDTH      number of checkpoint slots; one per B_MASK bit
// - PREGS     `PHYS_REG_SZ_R10K  width of the free-list snapshot
// PORTS
// - clock                  in   1                      single clock
// - reset                  in   1                      asynchronous, active-low
// - dispatch_entries       in   DEPTH x BS_ENTRY_PACKET  per-slot checkpoint from dispatch
// - next_b_mask            in   B_MASK                 dispatch's post-allocation mask
// - resolve_valid          in   1                      branch FU resolving this cycle
// - resolve_mask           in   B_MASK                 one-hot slot being resolved
// - resolve_mispredict     in   1                      1 = mispredicted
// - resolve_target_PC      in   ADDR                   correct next PC from branch FU
// - retire_free_mask       in   PREGS                  physical regs freed by retirement this cycle
// - b_mask_combinational   out  B_MASK                 slots live after this cycle's resolve
// - b_mm_resolve           out  B_MASK                 one-hot bit to clear in RS/FU/ROB on correct resolve
// - restore_valid          out  1                      misprediction restore this cycle
// - map_table_restore      out  ARCH_REG_SZ x PHYS_REG_IDX  snapshot map table
// - free_list_restore      out  PREGS                  snapshot free list, retire-merged
// - rob_tail_restore       out  ROB_SZ_BITS            ROB tail after the branch
// - b_mask_restore         out  B_MASK                 b_mask live at branch dispatch
// - restore_PC             out  ADDR                   = resolve_target_PC on restore
// - b_mm_squash            out  B_MASK                 slots killed (branch plus younger)
// BEHAVIOUR
// - State: entries[DEPTH] and valid_mask (B_MASK) registers.
// - reset low (async): valid_mask = 0, entries = 0, all outputs 0.
// - alloc = next_b_mask & ~b_mask_combinational.
//   - At posedge, each alloc bit j writes entries[j] = dispatch_entries[j] and sets valid_mask[j].
//   - Allocation into a slot already in valid_mask is illegal: assertion.
// - Resolve is combinational, zero latency; state updates at the following edge.
//   - Correct: b_mm_resolve = resolve_mask.
//     - Next edge: clear valid_mask bit, clear that bit in every stored entries[k].b_m.
//   - Mispredict: restore_valid = 1.
//     - Restore fields = entries[onehot(resolve_mask)], except free_list_restore, which also ORs retire_free_mask.
//     - b_mm_squash = resolve_mask | {k : valid_mask[k] & entries[k].b_m & resolve_mask}.
//     - Next edge: valid_mask &= ~b_mm_squash.
// - b_mask_combinational = valid_mask & ~(b_mm_resolve | b_mm_squash).
// - Retirement: each edge, entries[k].free_list |= retire_free_mask for every valid k.
//   - Restore never resurrects a freed reg.
// - Simultaneous alloc and mispredict: allocation dropped. Dispatch already stalls on restore_valid; assertion alloc==0.
// - Simultaneous alloc and correct resolve: both apply. A new entry's b_m has the resolved bit cleared before store.
// - resolve_valid with resolve_mask not one-hot, or not in valid_mask: assertion; outputs held 0.
// - resolve_valid = 0: restore_valid, b_mm_resolve and b_mm_squash are 0.
// - Full (valid_mask all 1s): dispatch stalls on branches. The block accepts no alloc.
// - Same-cycle resolve of the slot being allocated is impossible by construction.
// STRUCTURE
// - sys_defs.svh holds BS_ENTRY_PACKET, B_MASK, `B_MASK_WIDTH, `B_MASK_ID_BITS, ADDR.
//   - These types are shared with Dispatch, RS and ROB.
// - One sub-module: bs_onehot_mux, a one-hot select of BS_ENTRY_PACKET by resolve_mask.
// - Squash-mask and b_m-clear logic stay in the top.
// TESTING
// - Reset: drop reset mid-operation with 3 live slots -> b_mask_combinational = 0 and restore_valid = 0 immediately; no alloc accepted until reset high.
// - Alloc then correct resolve:
//   - next_b_mask = 4'b0001 -> slot 0 live.
//   - resolve 4'b0001 correct -> b_mm_resolve = 4'b0001, b_mask_combinational = 0 same cycle, slot free next cycle.
// - Nested mispredict:
//   - Alloc slots 0, then 1 (b_m = 0001), then 2 (b_m = 0011).
//   - Mispredict slot 1 -> b_mm_squash = 4'b0110, b_mask_restore = 4'b0001.
//   - rob_tail_restore and map_table_restore = slot 1 snapshot; restore_PC = resolve_target_PC.
// - Retire merge: snapshot free_list bit 40 = 0; retire_free_mask bit 40 next cycle; later mispredict -> free_list_restore[40] = 1.
// - Fill and wrap:
//   - Allocate all DEPTH slots -> b_mask_combinational = all ones.
//   - Resolve slot 2 correct, allocate again -> new entry lands in slot 2; other entries' b_m bit 2 cleared.
// - Same-cycle correct resolve of slot 0 and alloc of slot 1 with b_m = 0001 -> stored entries[1].b_m = 0.

Source files
------------

// File: rtl/branch_stack_pkg.sv
// Shared types for the branch checkpoint stack: slot mask, checkpoint packet and sizing.
package branch_stack_pkg;

  localparam int B_MASK_WIDTH   = 4;
  localparam int DEPTH          = B_MASK_WIDTH;
  localparam int PREGS          = 64;
  localparam int ARCH_REG_SZ    = 32;
  localparam int PHYS_REG_IDX_W = 6;
  localparam int ROB_SZ_BITS    = 5;
  localparam int ADDR_W         = 32;

  typedef logic [B_MASK_WIDTH-1:0]                      b_mask_t;
  typedef logic [ADDR_W-1:0]                            addr_t;
  typedef logic [PREGS-1:0]                             free_list_t;
  typedef logic [PHYS_REG_IDX_W-1:0]                    phys_idx_t;
  typedef logic [ARCH_REG_SZ-1:0][PHYS_REG_IDX_W-1:0]   map_table_t;
  typedef logic [ROB_SZ_BITS-1:0]                       rob_idx_t;

  typedef struct packed {
    b_mask_t    b_m;
    map_table_t map_table;
    free_list_t free_list;
    rob_idx_t   rob_tail;
  } bs_entry_t;

  function automatic logic is_onehot(input b_mask_t m);
    return (m != '0) && ((m & (m - b_mask_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/branch_stack_if.sv
// Dispatch / branch-FU side of the checkpoint stack: checkpoint writes, resolutions and restore data.
interface branch_stack_if;
  import branch_stack_pkg::*;

  bs_entry_t [DEPTH-1:0] dispatch_entries;
  b_mask_t               next_b_mask;
  logic                  resolve_valid;
  b_mask_t               resolve_mask;
  logic                  resolve_mispredict;
  addr_t                 resolve_target_PC;
  free_list_t            retire_free_mask;

  b_mask_t               b_mask_combinational;
  b_mask_t               b_mm_resolve;
  logic                  restore_valid;
  map_table_t            map_table_restore;
  free_list_t            free_list_restore;
  rob_idx_t              rob_tail_restore;
  b_mask_t               b_mask_restore;
  addr_t                 restore_PC;
  b_mask_t               b_mm_squash;

  modport master (
    output dispatch_entries, next_b_mask, resolve_valid, resolve_mask,
           resolve_mispredict, resolve_target_PC, retire_free_mask,
    input  b_mask_combinational, b_mm_resolve, restore_valid, map_table_restore,
           free_list_restore, rob_tail_restore, b_mask_restore, restore_PC, b_mm_squash
  );

  modport slave (
    input  dispatch_entries, next_b_mask, resolve_valid, resolve_mask,
           resolve_mispredict, resolve_target_PC, retire_free_mask,
    output b_mask_combinational, b_mm_resolve, restore_valid, map_table_restore,
           free_list_restore, rob_tail_restore, b_mask_restore, restore_PC, b_mm_squash
  );

endinterface

// File: rtl/branch_stack_onehot_mux.sv
// One-hot select of a checkpoint packet; an all-zero select yields an all-zero packet.
module bs_onehot_mux
  import branch_stack_pkg::*;
(
  input  bs_entry_t [DEPTH-1:0] entries,
  input  b_mask_t               sel,
  output bs_entry_t             entry_o
);

  always_comb begin
    entry_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sel[k]) entry_o = entry_o | entries[k];
    end
  end

endmodule

// File: rtl/branch_stack.sv
// Branch checkpoint store: one slot per b_mask bit, zero-latency resolve, restore on mispredict.
module branch_stack
  import branch_stack_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  branch_stack_if.slave  bs
);

  b_mask_t               valid_mask_q, valid_mask_d;
  bs_entry_t [DEPTH-1:0] entries_q, entries_d;

  logic      res_ok;
  logic      restore_valid;
  b_mask_t   b_mm_resolve;
  b_mask_t   b_mm_squash;
  b_mask_t   b_mask_comb;
  b_mask_t   alloc;
  b_mask_t   alloc_eff;
  bs_entry_t sel_entry;

  bs_onehot_mux u_mux (
    .entries (entries_q),
    .sel     (bs.resolve_mask),
    .entry_o (sel_entry)
  );

  // An illegal resolve (not one-hot or not live) is ignored entirely.
  always_comb begin
    res_ok        = bs.resolve_valid && is_onehot(bs.resolve_mask)
                    && ((bs.resolve_mask & valid_mask_q) != '0);
    restore_valid = res_ok && bs.resolve_mispredict;
    b_mm_resolve  = (res_ok && !bs.resolve_mispredict) ? bs.resolve_mask : '0;
    b_mm_squash   = '0;
    if (restore_valid) begin
      b_mm_squash = bs.resolve_mask;
      for (int k = 0; k < DEPTH; k++) begin
        if (valid_mask_q[k] && ((entries_q[k].b_m & bs.resolve_mask) != '0))
          b_mm_squash[k] = 1'b1;
      end
    end
    b_mask_comb = valid_mask_q & ~(b_mm_resolve | b_mm_squash);
    alloc       = bs.next_b_mask & ~b_mask_comb;
    alloc_eff   = restore_valid ? '0 : alloc;
  end

  always_comb begin
    bs.b_mask_combinational = b_mask_comb;
    bs.b_mm_resolve         = b_mm_resolve;
    bs.b_mm_squash          = b_mm_squash;
    bs.restore_valid        = restore_valid;
    bs.map_table_restore    = restore_valid ? sel_entry.map_table : '0;
    bs.free_list_restore    = restore_valid ? (sel_entry.free_list | bs.retire_free_mask) : '0;
    bs.rob_tail_restore     = restore_valid ? sel_entry.rob_tail : '0;
    bs.b_mask_restore       = restore_valid ? sel_entry.b_m : '0;
    bs.restore_PC           = restore_valid ? bs.resolve_target_PC : '0;
  end

  // New checkpoints also absorb this cycle's retire frees so a restore never revives a freed reg.
  always_comb begin
    valid_mask_d = (valid_mask_q & ~(b_mm_resolve | b_mm_squash)) | alloc_eff;
    entries_d    = entries_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (alloc_eff[k]) begin
        entries_d[k]           = bs.dispatch_entries[k];
        entries_d[k].b_m       = bs.dispatch_entries[k].b_m & ~b_mm_resolve;
        entries_d[k].free_list = bs.dispatch_entries[k].free_list | bs.retire_free_mask;
      end else begin
        entries_d[k].b_m = entries_q[k].b_m & ~b_mm_resolve;
        if (valid_mask_q[k])
          entries_d[k].free_list = entries_q[k].free_list | bs.retire_free_mask;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_mask_q <= '0;
      entries_q    <= '0;
    end else begin
      valid_mask_q <= valid_mask_d;
      entries_q    <= entries_d;
    end
  end

  a_alloc_into_live: assert property (@(posedge clock) disable iff (!reset)
    (alloc & valid_mask_q) == '0);

  a_no_alloc_on_restore: assert property (@(posedge clock) disable iff (!reset)
    restore_valid |-> (alloc == '0));

  a_resolve_legal: assert property (@(posedge clock) disable iff (!reset)
    bs.resolve_valid |-> (is_onehot(bs.resolve_mask) && ((bs.resolve_mask & valid_mask_q) != '0)));

endmodule

// File: tb/tb_branch_stack.sv
// Directed bench for branch_stack: expected outputs are queued per step and compared after settling.
module tb_branch_stack;
  import branch_stack_pkg::*;

  logic clock;
  logic reset;

  branch_stack_if bs_if ();

  branch_stack u_dut (
    .clock (clock),
    .reset (reset),
    .bs    (bs_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    b_mask_t   comb;
    b_mask_t   res;
    logic      rv;
    b_mask_t   sq;
    b_mask_t   bmr;
    rob_idx_t  rob;
    phys_idx_t map5;
    addr_t     pc;
    logic      fl40;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors    = 0;
  int    miscompares = 0;

  function automatic bs_entry_t mk_entry(input b_mask_t bm, input rob_idx_t rob, input phys_idx_t map5);
    bs_entry_t e;
    e              = '0;
    e.b_m          = bm;
    e.rob_tail     = rob;
    e.map_table[5] = map5;
    e.map_table[0] = phys_idx_t'(1);
    e.free_list    = 64'h0000_0000_0000_00FF;
    return e;
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  task automatic expect_out(input string tag, input b_mask_t comb, input b_mask_t res, input logic rv,
                            input b_mask_t sq, input b_mask_t bmr, input rob_idx_t rob,
                            input phys_idx_t map5, input addr_t pc, input logic fl40);
    exp_t e;
    e.comb = comb; e.res = res; e.rv = rv; e.sq = sq; e.bmr = bmr;
    e.rob = rob; e.map5 = map5; e.pc = pc; e.fl40 = fl40;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic expect_live(input string tag, input b_mask_t comb, input b_mask_t res);
    expect_out(tag, comb, res, 1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic expect_restore(input string tag, input b_mask_t comb, input b_mask_t sq, input b_mask_t bmr,
                                input rob_idx_t rob, input phys_idx_t map5, input addr_t pc, input logic fl40);
    expect_out(tag, comb, '0, 1'b1, sq, bmr, rob, map5, pc, fl40);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp(t, "b_mask_comb",   64'(bs_if.b_mask_combinational), 64'(e.comb));
      cmp(t, "b_mm_resolve",  64'(bs_if.b_mm_resolve),         64'(e.res));
      cmp(t, "restore_valid", 64'(bs_if.restore_valid),        64'(e.rv));
      cmp(t, "b_mm_squash",   64'(bs_if.b_mm_squash),          64'(e.sq));
      cmp(t, "b_mask_rest",   64'(bs_if.b_mask_restore),       64'(e.bmr));
      cmp(t, "rob_tail_rest", 64'(bs_if.rob_tail_restore),     64'(e.rob));
      cmp(t, "map5_rest",     64'(bs_if.map_table_restore[5]), 64'(e.map5));
      cmp(t, "restore_pc",    64'(bs_if.restore_PC),           64'(e.pc));
      cmp(t, "free40_rest",   64'(bs_if.free_list_restore[40]), 64'(e.fl40));
    end
  endtask

  task automatic drive(input b_mask_t next_mask, input logic rv_in, input b_mask_t rmask,
                       input logic mis, input addr_t pc, input free_list_t retire);
    @(negedge clock);
    bs_if.dispatch_entries   = '0;
    bs_if.next_b_mask        = next_mask;
    bs_if.resolve_valid      = rv_in;
    bs_if.resolve_mask       = rmask;
    bs_if.resolve_mispredict = mis;
    bs_if.resolve_target_PC  = pc;
    bs_if.retire_free_mask   = retire;
  endtask

  task automatic alloc(input int slot, input b_mask_t next_mask, input bs_entry_t e);
    drive(next_mask, 1'b0, '0, 1'b0, '0, '0);
    bs_if.dispatch_entries[slot] = e;
  endtask

  free_list_t retire40;

  initial begin
    retire40 = '0;
    retire40[40] = 1'b1;
    reset = 1'b0;
    bs_if.dispatch_entries   = '0;
    bs_if.next_b_mask        = '0;
    bs_if.resolve_valid      = 1'b0;
    bs_if.resolve_mask       = '0;
    bs_if.resolve_mispredict = 1'b0;
    bs_if.resolve_target_PC  = '0;
    bs_if.retire_free_mask   = '0;
    #2;
    expect_live("reset", 4'b0000, 4'b0000);
    check_out();
    @(negedge clock);
    reset = 1'b1;

    // single alloc, then correct resolve
    alloc(0, 4'b0001, mk_entry(4'b0000, 5'd3, 6'd7));
    expect_live("alloc0", 4'b0000, 4'b0000); check_out();
    drive(4'b0000, 1'b1, 4'b0001, 1'b0, '0, '0);
    expect_live("resolve0", 4'b0000, 4'b0001); check_out();
    drive(4'b0000, 1'b0, '0, 1'b0, '0, '0);
    expect_live("freed0", 4'b0000, 4'b0000); check_out();

    // nested branches, retire merge, mispredict of the middle one
    alloc(0, 4'b0001, mk_entry(4'b0000, 5'd4, 6'd10));
    expect_live("nest_a0", 4'b0000, 4'b0000); check_out();
    alloc(1, 4'b0011, mk_entry(4'b0001, 5'd8, 6'd11));
    expect_live("nest_a1", 4'b0001, 4'b0000); check_out();
    alloc(2, 4'b0111, mk_entry(4'b0011, 5'd12, 6'd12));
    expect_live("nest_a2", 4'b0011, 4'b0000); check_out();
    drive(4'b0111, 1'b0, '0, 1'b0, '0, retire40);
    expect_live("retire40", 4'b0111, 4'b0000); check_out();
    drive(4'b0000, 1'b1, 4'b0010, 1'b1, 32'h0000_4000, '0);
    expect_restore("mispred1", 4'b0001, 4'b0110, 4'b0001, 5'd8, 6'd11, 32'h0000_4000, 1'b1); check_out();
    drive(4'b0001, 1'b0, '0, 1'b0, '0, '0);
    expect_live("after_mp1", 4'b0001, 4'b0000); check_out();
    drive(4'b0000, 1'b1, 4'b0001, 1'b1, 32'h0000_8000, '0);
    expect_restore("mispred0", 4'b0000, 4'b0001, 4'b0000, 5'd4, 6'd10, 32'h0000_8000, 1'b1); check_out();
    drive(4'b0000, 1'b0, '0, 1'b0, '0, '0);
    expect_live("empty", 4'b0000, 4'b0000); check_out();

    // fill every slot, free slot 2, refill it
    alloc(0, 4'b0001, mk_entry(4'b0000, 5'd1, 6'd1));
    expect_live("fill0", 4'b0000, 4'b0000); check_out();
    alloc(1, 4'b0011, mk_entry(4'b0001, 5'd2, 6'd2));
    expect_live("fill1", 4'b0001, 4'b0000); check_out();
    alloc(2, 4'b0111, mk_entry(4'b0011, 5'd3, 6'd3));
    expect_live("fill2", 4'b0011, 4'b0000); check_out();
    alloc(3, 4'b1111, mk_entry(4'b0111, 5'd4, 6'd4));
    expect_live("fill3", 4'b0111, 4'b0000); check_out();
    drive(4'b1111, 1'b0, '0, 1'b0, '0, '0);
    expect_live("full", 4'b1111, 4'b0000); check_out();
    drive(4'b1011, 1'b1, 4'b0100, 1'b0, '0, '0);
    expect_live("resolve2", 4'b1011, 4'b0100); check_out();
    alloc(2, 4'b1111, mk_entry(4'b1011, 5'd20, 6'd20));
    expect_live("wrap2", 4'b1011, 4'b0000); check_out();
    drive(4'b1111, 1'b0, '0, 1'b0, '0, '0);
    expect_live("full2", 4'b1111, 4'b0000); check_out();
    drive(4'b0000, 1'b1, 4'b1000, 1'b1, 32'h0000_0C00, '0);
    expect_restore("mispred3", 4'b0011, 4'b1100, 4'b0011, 5'd4, 6'd4, 32'h0000_0C00, 1'b0); check_out();
    drive(4'b0011, 1'b0, '0, 1'b0, '0, '0);
    expect_live("after_mp3", 4'b0011, 4'b0000); check_out();
    drive(4'b0000, 1'b1, 4'b0001, 1'b1, 32'h0000_0100, '0);
    expect_restore("flush0", 4'b0000, 4'b0011, 4'b0000, 5'd1, 6'd1, 32'h0000_0100, 1'b0); check_out();

    // correct resolve of slot 0 in the same cycle slot 1 is allocated under it
    alloc(0, 4'b0001, mk_entry(4'b0000, 5'd6, 6'd6));
    expect_live("same_a0", 4'b0000, 4'b0000); check_out();
    alloc(1, 4'b0010, mk_entry(4'b0001, 5'd9, 6'd9));
    bs_if.resolve_valid = 1'b1;
    bs_if.resolve_mask  = 4'b0001;
    expect_live("same_res", 4'b0000, 4'b0001); check_out();
    drive(4'b0010, 1'b0, '0, 1'b0, '0, '0);
    expect_live("same_live", 4'b0010, 4'b0000); check_out();
    drive(4'b0000, 1'b1, 4'b0010, 1'b1, 32'h0000_0200, '0);
    expect_restore("same_bm", 4'b0000, 4'b0010, 4'b0000, 5'd9, 6'd9, 32'h0000_0200, 1'b0); check_out();

    // reset mid-operation with three live slots
    alloc(0, 4'b0001, mk_entry(4'b0000, 5'd1, 6'd1));
    expect_live("rst_a0", 4'b0000, 4'b0000); check_out();
    alloc(1, 4'b0011, mk_entry(4'b0001, 5'd2, 6'd2));
    expect_live("rst_a1", 4'b0001, 4'b0000); check_out();
    alloc(2, 4'b0111, mk_entry(4'b0011, 5'd3, 6'd3));
    expect_live("rst_a2", 4'b0011, 4'b0000); check_out();
    drive(4'b0000, 1'b1, 4'b0010, 1'b1, 32'h0000_0300, '0);
    expect_restore("rst_pre", 4'b0001, 4'b0110, 4'b0001, 5'd2, 6'd2, 32'h0000_0300, 1'b0); check_out();
    reset = 1'b0;
    bs_if.next_b_mask = 4'b0001;
    bs_if.dispatch_entries[0] = mk_entry(4'b0000, 5'd5, 6'd5);
    expect_live("rst_drop", 4'b0000, 4'b0000); check_out();
    @(negedge clock);
    expect_live("rst_hold", 4'b0000, 4'b0000); check_out();
    drive(4'b0000, 1'b0, '0, 1'b0, '0, '0);
    reset = 1'b1;
    expect_live("rst_rel", 4'b0000, 4'b0000); check_out();
    alloc(3, 4'b1000, mk_entry(4'b0000, 5'd7, 6'd7));
    expect_live("post_a3", 4'b0000, 4'b0000); check_out();
    drive(4'b1000, 1'b0, '0, 1'b0, '0, '0);
    expect_live("post_live", 4'b1000, 4'b0000); check_out();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
